// File: rtl/fp_pkg.sv
// Shared fingerprint constants and types for the compare path.
// Scorer state names are used by fp_match_scorer.
package fp_pkg;
  localparam int FP_DIM             = 160;
  localparam int FP_WORDS           = 1600;
  localparam int SAVE_BEGIN_ADDRESS = 13000;
  localparam int DB_SIZE_ADDRESS    = 12999;
  localparam int FP_SIZE            = 1600;

  typedef logic [15:0] score_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_LIVE = 2'd1,
    RD_TMPL = 2'd2,
    DONE    = 2'd3
  } state_e;
endpackage

// File: rtl/fp_match_scorer_popcount16.sv
// Combinational 16-bit population count built as a balanced adder tree.
module fp_popcount16 (
  input  logic [15:0] i_data,
  output logic [4:0]  o_count
);
  logic [1:0] w_l1 [8];
  logic [2:0] w_l2 [4];
  logic [3:0] w_l3 [2];

  genvar g;
  for (g = 0; g < 8; g++) begin : g_l1
    assign w_l1[g] = {1'b0, i_data[2*g]} + {1'b0, i_data[2*g+1]};
  end
  for (g = 0; g < 4; g++) begin : g_l2
    assign w_l2[g] = {1'b0, w_l1[2*g]} + {1'b0, w_l1[2*g+1]};
  end
  for (g = 0; g < 2; g++) begin : g_l3
    assign w_l3[g] = {1'b0, w_l2[2*g]} + {1'b0, w_l2[2*g+1]};
  end

  assign o_count = {1'b0, w_l3[0]} + {1'b0, w_l3[1]};
endmodule

// File: rtl/fp_match_scorer.sv
// Streams live and template words from SRAM in alternation and counts agreeing bits.
// Address is registered one cycle ahead so SRAM data lines up with the state that consumes it.
module fp_match_scorer #(
  parameter int FP_WORDS = 1600,
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int SCORE_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_live_addr,
  input  logic [ADDR_W-1:0] i_tmpl_addr,
  input  logic [SCORE_W-1:0] i_threshold,
  output logic [ADDR_W-1:0] o_sram_addr,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic              o_busy,
  output logic              o_finish,
  output logic [SCORE_W-1:0] o_score,
  output logic              o_match
);
  import fp_pkg::*;

  localparam logic [10:0] LAST_IDX = 11'(FP_WORDS - 1);

  state_e              r_state;
  state_e              w_next;
  logic [ADDR_W-1:0]   r_live_base;
  logic [ADDR_W-1:0]   r_tmpl_base;
  logic [ADDR_W-1:0]   r_addr;
  logic [SCORE_W-1:0]  r_thr;
  logic [SCORE_W-1:0]  r_acc;
  logic [SCORE_W-1:0]  r_score;
  logic                r_match;
  logic [10:0]         r_idx;
  logic [DATA_W-1:0]   r_live;
  logic [DATA_W-1:0]   w_agree;
  logic [4:0]          w_pc;
  logic [SCORE_W-1:0]  w_acc_next;
  logic                w_last;
  logic                w_busy;
  logic                w_finish;

  assign w_agree    = ~(r_live ^ i_sram_data);
  assign w_acc_next = r_acc + SCORE_W'(w_pc);
  assign w_last     = (r_idx == LAST_IDX);

  fp_popcount16 u_popcount (
    .i_data  (w_agree),
    .o_count (w_pc)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = RD_LIVE;
      RD_LIVE: w_next = RD_TMPL;
      RD_TMPL: w_next = w_last ? DONE : RD_LIVE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state != IDLE);
    w_finish = (r_state == DONE);
  end

  // The address loaded here is the one presented during the state being entered.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_live_base <= '0;
      r_tmpl_base <= '0;
      r_addr      <= '0;
      r_thr       <= '0;
      r_acc       <= '0;
      r_score     <= '0;
      r_match     <= 1'b0;
      r_idx       <= '0;
      r_live      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_live_base <= i_live_addr;
            r_tmpl_base <= i_tmpl_addr;
            r_thr       <= i_threshold;
            r_idx       <= '0;
            r_acc       <= '0;
            r_score     <= '0;
            r_match     <= 1'b0;
            r_addr      <= i_live_addr;
          end else begin
            r_addr <= '0;
          end
        end
        RD_LIVE: begin
          r_live <= i_sram_data;
          r_addr <= r_tmpl_base + ADDR_W'(r_idx);
        end
        RD_TMPL: begin
          r_acc <= w_acc_next;
          if (w_last) begin
            r_score <= w_acc_next;
            r_match <= (w_acc_next > r_thr);
            r_addr  <= '0;
          end else begin
            r_idx  <= r_idx + 11'd1;
            r_addr <= r_live_base + ADDR_W'(r_idx + 11'd1);
          end
        end
        DONE: r_addr <= '0;
        default: r_addr <= '0;
      endcase
    end
  end

  assign o_sram_addr = r_addr;
  assign o_busy      = w_busy;
  assign o_finish    = w_finish;
  assign o_score     = r_score;
  assign o_match     = r_match;
endmodule

// File: tb/tb_fp_match_scorer.sv
// Self-checking bench: timeline model of a scoring run plus directed and random scenarios.
module tb_fp_match_scorer;
  localparam int FPW      = fp_pkg::FP_WORDS;
  localparam int DONE_CYC = 2 * FPW + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [19:0] live_addr = '0;
  logic [19:0] tmpl_addr = '0;
  logic [15:0] thr = '0;
  logic [19:0] sram_addr;
  logic [15:0] sram_data;
  logic        busy, finish, match;
  logic [15:0] score;

  logic [15:0] mem [0:(1<<20)-1];
  assign sram_data = mem[sram_addr];

  always #5 clk = ~clk;

  fp_match_scorer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_live_addr (live_addr),
    .i_tmpl_addr (tmpl_addr),
    .i_threshold (thr),
    .o_sram_addr (sram_addr),
    .i_sram_data (sram_data),
    .o_busy      (busy),
    .o_finish    (finish),
    .o_score     (score),
    .o_match     (match)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_fin    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (clk %0d)", name, act, exp, cyc);
  endtask

  function automatic int ref_score(input logic [19:0] lb, input logic [19:0] tb);
    int s = 0;
    for (int i = 0; i < FPW; i++)
      s += $countones(~(mem[lb + 20'(i)] ^ mem[tb + 20'(i)]));
    return s;
  endfunction

  // Run timeline: m_k = cycle index within a run (1..DONE_CYC), -1 when idle.
  int          m_k = -1;
  logic [19:0] m_live = '0, m_tmpl = '0;
  logic [15:0] m_thr = '0;
  int          m_final = 0;
  int          m_score = 0;
  bit          m_match = 1'b0;
  bit          model_on = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    model_on <= 1'b1;
    if (!rst_n) begin
      m_k <= -1; m_score <= 0; m_match <= 1'b0;
    end else if (m_k == DONE_CYC) begin
      m_k <= -1;
    end else if (m_k == -1) begin
      if (start) begin
        m_k     <= 1;
        m_live  <= live_addr;
        m_tmpl  <= tmpl_addr;
        m_thr   <= thr;
        m_score <= 0;
        m_match <= 1'b0;
        m_final <= ref_score(live_addr, tmpl_addr);
      end
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == DONE_CYC) begin
        m_score <= m_final;
        m_match <= (m_final > int'(m_thr));
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [19:0] ea;
    if (model_on) begin
      ea = '0;
      if (m_k >= 1 && m_k <= 2 * FPW)
        ea = (m_k % 2 == 1) ? m_live + 20'((m_k - 1) / 2) : m_tmpl + 20'(m_k / 2 - 1);
      chk("addr",   int'(sram_addr), int'(ea));
      chk("busy",   int'(busy),      int'(m_k >= 1));
      chk("finish", int'(finish),    int'(m_k == DONE_CYC));
      chk("score",  int'(score),     m_score);
      chk("match",  int'(match),     int'(m_match));
      if (finish) n_fin++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_pair(input logic [19:0] lb, input logic [19:0] tb, input int dens);
    logic [15:0] w, m;
    for (int i = 0; i < FPW; i++) begin
      w = 16'($urandom);
      m = (dens == 0) ? 16'h0 : (dens == 1) ? 16'($urandom & $urandom & $urandom) : 16'($urandom);
      mem[lb + 20'(i)] = w;
      mem[tb + 20'(i)] = w ^ m;
    end
  endtask

  task automatic fill_const(input logic [19:0] b, input logic [15:0] v);
    for (int i = 0; i < FPW; i++) mem[b + 20'(i)] = v;
  endtask

  // base = edge count of cycle 0, so (cyc - base) is the cycle index.
  task automatic start_run(input logic [19:0] lb, input logic [19:0] tb, input logic [15:0] th,
                           output int base);
    live_addr = lb; tmpl_addr = tb; thr = th; start = 1'b1;
    tick(1);
    base = cyc - 1;
    start = 1'b0;
    live_addr = 20'($urandom); tmpl_addr = 20'($urandom); thr = 16'($urandom);
  endtask

  task automatic wait_fin(input string tag, input int base, output int lat);
    int k = 0;
    while (!finish && k < 4000) begin @(negedge clk); k++; end
    if (!finish) begin
      n_checks++;
      $display("FAIL %s_timeout: no o_finish within 4000 cycles", tag);
      lat = -1;
    end else lat = cyc - base;
  endtask

  task automatic do_run(input string tag, input logic [19:0] lb, input logic [19:0] tb,
                        input logic [15:0] th, output int sc, output int mt);
    int base, lat;
    start_run(lb, tb, th, base);
    wait_fin(tag, base, lat);
    chk({tag, "_lat"}, lat, DONE_CYC);
    sc = int'(score); mt = int'(match);
    tick(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sc, mt, base, lat, f0, e;
    logic [19:0] lb, tb;
    logic [15:0] th;

    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_addr",  int'(sram_addr), 0);
    chk("rst_score", int'(score), 0);

    fill_pair(20'h10000, 20'h20000, 0);
    do_run("ident", 20'h10000, 20'h20000, 16'd1800, sc, mt);
    chk("ident_score", sc, 25600);
    chk("ident_match", mt, 1);

    fill_const(20'h30000, 16'h0000);
    fill_const(20'h40000, 16'hFFFF);
    do_run("oppos", 20'h30000, 20'h40000, 16'd1800, sc, mt);
    chk("oppos_score", sc, 0);
    chk("oppos_match", mt, 0);

    for (int i = 0; i < FPW; i++) mem[20'h50000 + 20'(i)] = mem[20'h10000 + 20'(i)];
    mem[20'h50000 + 20'd800] = mem[20'h50000 + 20'd800] ^ 16'h0421;
    do_run("flip_eq", 20'h10000, 20'h50000, 16'd25597, sc, mt);
    chk("flip_eq_score", sc, 25597);
    chk("flip_eq_match", mt, 0);
    do_run("flip_lt", 20'h10000, 20'h50000, 16'd25596, sc, mt);
    chk("flip_lt_score", sc, 25597);
    chk("flip_lt_match", mt, 1);

    f0 = n_fin;
    start_run(20'h10000, 20'h20000, 16'd1800, base);
    tick(99);
    start = 1'b1; tick(1); start = 1'b0;
    wait_fin("ignore", base, lat);
    chk("ignore_lat", lat, DONE_CYC);
    tick(3);
    chk("ignore_fin_count", n_fin - f0, 1);

    live_addr = 20'h30000; tmpl_addr = 20'h40000; thr = 16'd5; start = 1'b1;
    tick(1);
    base = cyc - 1;
    wait_fin("held1", base, lat);
    chk("held1_lat", lat, DONE_CYC);
    chk("held1_score", int'(score), 0);
    live_addr = 20'h10000; tmpl_addr = 20'h20000; thr = 16'd1800;
    tick(2);
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_score_cleared", int'(score), 0);
    chk("b2b_addr", int'(sram_addr), 'h10000);
    base = cyc - 1;
    start = 1'b0;
    wait_fin("held2", base, lat);
    chk("held2_lat", lat, DONE_CYC);
    chk("held2_score", int'(score), 25600);
    chk("held2_match", int'(match), 1);
    tick(1);

    start_run(20'h10000, 20'h20000, 16'd1800, base);
    tick(1499);
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    chk("mid_rst_busy",   int'(busy), 0);
    chk("mid_rst_addr",   int'(sram_addr), 0);
    chk("mid_rst_finish", int'(finish), 0);
    chk("mid_rst_score",  int'(score), 0);
    f0 = n_fin;
    tick(3400);
    chk("mid_rst_no_fin", n_fin - f0, 0);
    do_run("post_rst", 20'h10000, 20'h50000, 16'd100, sc, mt);
    chk("post_rst_score", sc, 25597);
    chk("post_rst_match", mt, 1);

    fill_pair(20'hFFF00, 20'h60000, 2);
    e = ref_score(20'hFFF00, 20'h60000);
    start_run(20'hFFF00, 20'h60000, 16'd12800, base);
    tick(510);
    chk("wrap_addr_last", int'(sram_addr), 'hFFFFF);
    tick(2);
    chk("wrap_addr_zero", int'(sram_addr), 0);
    wait_fin("wrap", base, lat);
    chk("wrap_lat", lat, DONE_CYC);
    chk("wrap_score", int'(score), e);
    chk("wrap_match", int'(match), int'(e > 12800));
    tick(1);

    for (int r = 0; r < 3; r++) begin
      lb = 20'($urandom);
      tb = lb + 20'h80000;
      fill_pair(lb, tb, 1);
      e  = ref_score(lb, tb);
      th = (r == 0) ? 16'(e) : (r == 1) ? 16'(e - 1) : 16'($urandom_range(20000, 25600));
      do_run("rand", lb, tb, th, sc, mt);
      chk("rand_score", sc, e);
      chk("rand_match", mt, int'(e > int'(th)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
